// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, parity-type encodings and the
// prescale legality check used by both the RX and TX serializer paths.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic prescale_legal(input int unsigned prescale);
        return (prescale == 8) || (prescale == 16) || (prescale == 32);
    endfunction

endpackage

// File: rtl/uart_rx_data_sampler.sv
// Three-tap mid-bit capture with majority vote; taps register one cycle after their tick,
// so the vote is stable by the last tick of the bit. No backpressure: runs every cycle.
module uart_rx_data_sampler #(
    parameter int unsigned PRESCALE = 8,
    parameter int unsigned EW       = $clog2(PRESCALE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_i,
    input  logic [EW-1:0] edge_cnt_i,
    output logic          bit_o
);

    localparam logic [EW-1:0] TAP_EARLY = EW'(PRESCALE / 2 - 1);
    localparam logic [EW-1:0] TAP_MID   = EW'(PRESCALE / 2);
    localparam logic [EW-1:0] TAP_LATE  = EW'(PRESCALE / 2 + 1);

    logic [2:0] taps_q;
    logic [2:0] taps_d;

    always_comb begin
        taps_d = taps_q;
        if (edge_cnt_i == TAP_EARLY) taps_d[0] = rx_i;
        if (edge_cnt_i == TAP_MID)   taps_d[1] = rx_i;
        if (edge_cnt_i == TAP_LATE)  taps_d[2] = rx_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            taps_q <= '0;
        end else begin
            taps_q <= taps_d;
        end
    end

    assign bit_o = (taps_q[0] & taps_q[1]) | (taps_q[0] & taps_q[2]) | (taps_q[1] & taps_q[2]);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: start detect, majority-voted bits, LSB-first deserialize, parity/stop checks.
// Strobes land (2+DATA_WIDTH+PAR_EN)*PRESCALE cycles after the line falls; no backpressure.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int unsigned EW = $clog2(PRESCALE);
    localparam int unsigned BW = $clog2(DATA_WIDTH);
    localparam logic [EW-1:0] LAST_TICK = EW'(PRESCALE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

    if (!prescale_legal(PRESCALE)) begin : g_bad_prescale
        $error("uart_rx_core: PRESCALE must be 8, 16 or 32");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
        $error("uart_rx_core: DATA_WIDTH must be 5..9");
    end

    rx_state_e             state_q, state_d;
    logic [EW-1:0]         edge_cnt_q, edge_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_bad_q, par_bad_d;
    logic                  dv_q, dv_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;
    logic                  sampled_bit;
    logic                  tick_last;

    // In IDLE the counter sits at 0, which is exactly tick 0 of a start bit.
    uart_rx_data_sampler #(
        .PRESCALE (PRESCALE),
        .EW       (EW)
    ) u_sampler (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (RX_IN),
        .edge_cnt_i (edge_cnt_q),
        .bit_o      (sampled_bit)
    );

    assign tick_last = (edge_cnt_q == LAST_TICK);

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        p_data_d   = p_data_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_bad_d  = par_bad_q;
        dv_d       = 1'b0;
        perr_d     = 1'b0;
        serr_d     = 1'b0;

        if (state_q != ST_IDLE) begin
            edge_cnt_d = tick_last ? '0 : edge_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!RX_IN) begin
                    state_d    = ST_START;
                    edge_cnt_d = EW'(1);
                    bit_cnt_d  = '0;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_bad_d  = 1'b0;
                end
            end
            ST_START: begin
                if (tick_last) state_d = sampled_bit ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (tick_last) begin
                    shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick_last) begin
                    par_bad_d = sampled_bit != ((^shift_q) ^ (par_typ_q == PAR_ODD));
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick_last) begin
                    state_d = ST_IDLE;
                    dv_d    = !par_bad_q && sampled_bit;
                    perr_d  = par_bad_q;
                    serr_d  = !sampled_bit;
                    if (!par_bad_q && sampled_bit) p_data_d = shift_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            p_data_q   <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bad_q  <= 1'b0;
            dv_q       <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            p_data_q   <= p_data_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_bad_q  <= par_bad_d;
            dv_q       <= dv_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = dv_q;
    assign par_err    = perr_q;
    assign stp_err    = serr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: per-cycle line waveforms decoded by a frame-level model.
module tb_uart_rx_core;

    localparam int DW = 8;
    localparam int PS = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          RX_IN;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    logic          busy;

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] exp_pdata;
    bit            wave[$];

    always #5 clk = ~clk;

    uart_rx_core #(.DATA_WIDTH(DW), .PRESCALE(PS)) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line waveform of one frame, one entry per clock cycle.
    task automatic build(input logic [DW-1:0] d, input bit pe, input bit pt,
                         input bit flip, input bit stopb);
        bit bits[$];
        wave.delete();
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
        if (pe) bits.push_back((^d) ^ pt ^ flip);
        bits.push_back(stopb);
        foreach (bits[i]) for (int k = 0; k < PS; k++) wave.push_back(bits[i]);
    endtask

    function automatic bit maj(input int b);
        int s;
        s = int'(wave[b*PS + PS/2 - 1]) + int'(wave[b*PS + PS/2]) + int'(wave[b*PS + PS/2 + 1]);
        return s >= 2;
    endfunction

    // Frame-level reference: what the receiver must report and on which cycle.
    task automatic decode(input bit pe, input bit pt, output int end_c, output bit dv,
                          output bit perr, output bit serr, output logic [DW-1:0] dat);
        dat  = '0;
        dv   = 1'b0;
        perr = 1'b0;
        serr = 1'b0;
        if (maj(0)) begin
            end_c = PS - 1;
        end else begin
            for (int i = 0; i < DW; i++) dat[i] = maj(1 + i);
            perr  = pe && (maj(1 + DW) != ((^dat) ^ pt));
            serr  = !maj(1 + DW + int'(pe));
            dv    = !perr && !serr;
            end_c = (2 + DW + int'(pe)) * PS - 1;
        end
    endtask

    // Entered and left on a negedge, so consecutive calls give zero-gap frames.
    task automatic run_wave(input bit pe, input bit pt, input string tag);
        int            end_c;
        bit            dv, perr, serr;
        logic [DW-1:0] dat;
        int            busy_bad = 0;
        int            stray    = 0;
        decode(pe, pt, end_c, dv, perr, serr, dat);
        for (int c = 0; c < wave.size(); c++) begin
            RX_IN = wave[c];
            if (c == 0) begin
                PAR_EN  = pe;
                PAR_TYP = pt;
            end else begin
                PAR_EN  = 1'($urandom_range(0, 1));
                PAR_TYP = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (c == end_c) begin
                if (dv) exp_pdata = dat;
                chk({tag, "/data_valid"}, 32'(data_valid), 32'(dv));
                chk({tag, "/par_err"}, 32'(par_err), 32'(perr));
                chk({tag, "/stp_err"}, 32'(stp_err), 32'(serr));
                chk({tag, "/P_DATA"}, 32'(P_DATA), 32'(exp_pdata));
            end else begin
                if (busy !== (c < end_c)) busy_bad++;
                if ({data_valid, par_err, stp_err} !== 3'b000) stray++;
            end
        end
        chk({tag, "/busy_profile"}, 32'(busy_bad), 32'(0));
        chk({tag, "/stray_strobes"}, 32'(stray), 32'(0));
    endtask

    task automatic idle(input int n);
        int noisy = 0;
        RX_IN = 1'b1;
        repeat (n) begin
            @(negedge clk);
            if ({busy, data_valid, par_err, stp_err} !== 4'b0000) noisy++;
        end
        chk("idle_quiet", 32'(noisy), 32'(0));
    endtask

    initial begin
        int            gpos;
        int            gap;
        logic [DW-1:0] d;
        bit            pe, pt, flip, stopb;

        rst       = 1'b1;
        RX_IN     = 1'b1;
        PAR_EN    = 1'b0;
        PAR_TYP   = 1'b0;
        exp_pdata = '0;
        repeat (3) @(negedge clk);
        chk("reset/P_DATA", 32'(P_DATA), 32'(0));
        chk("reset/data_valid", 32'(data_valid), 32'(0));
        chk("reset/par_err", 32'(par_err), 32'(0));
        chk("reset/stp_err", 32'(stp_err), 32'(0));
        chk("reset/busy", 32'(busy), 32'(0));
        rst = 1'b0;
        idle(4);

        build(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        run_wave(1'b0, 1'b0, "a5_plain");
        idle(3);

        build(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
        run_wave(1'b1, 1'b0, "3c_par_ok");
        idle(2);
        build(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
        run_wave(1'b1, 1'b0, "3c_par_bad");
        idle(2);

        build(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        run_wave(1'b0, 1'b0, "5a_stop_bad");
        build(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
        run_wave(1'b0, 1'b0, "81_after_err");
        idle(2);

        wave.delete();
        for (int c = 0; c < 2 * PS; c++) wave.push_back(c >= 3);
        run_wave(1'b0, 1'b0, "start_glitch");
        idle(2);

        build(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
        wave[3*PS + 4] = ~wave[3*PS + 4];
        run_wave(1'b0, 1'b0, "f0_pulse");
        idle(2);

        wave.delete();
        for (int c = 0; c < (2 + DW) * PS; c++) wave.push_back(1'b0);
        run_wave(1'b0, 1'b0, "break1");
        run_wave(1'b0, 1'b0, "break2");
        idle(3);

        build(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        run_wave(1'b0, 1'b0, "b2b_11");
        build(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
        run_wave(1'b0, 1'b0, "b2b_22");
        build(8'h44, 1'b0, 1'b0, 1'b0, 1'b1);
        begin
            int stray = 0;
            for (int c = 0; c <= 5 * PS + 2; c++) begin
                RX_IN = wave[c];
                @(negedge clk);
                if ({data_valid, par_err, stp_err} !== 3'b000) stray++;
            end
            chk("midrst/partial_strobes", 32'(stray), 32'(0));
        end
        rst   = 1'b1;
        RX_IN = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_pdata = '0;
        chk("midrst/P_DATA", 32'(P_DATA), 32'(0));
        chk("midrst/busy", 32'(busy), 32'(0));
        chk("midrst/strobes", 32'({data_valid, par_err, stp_err}), 32'(0));
        idle(PS * 12);
        build(8'h33, 1'b0, 1'b0, 1'b0, 1'b1);
        run_wave(1'b0, 1'b0, "33_after_rst");

        for (int n = 0; n < 25; n++) begin
            d     = DW'($urandom);
            pe    = 1'($urandom_range(0, 1));
            pt    = 1'($urandom_range(0, 1));
            flip  = ($urandom_range(0, 3) == 0);
            stopb = ($urandom_range(0, 3) != 0);
            build(d, pe, pt, flip, stopb);
            if ($urandom_range(0, 1) == 1) begin
                gpos       = int'($urandom_range(PS, wave.size() - 1));
                wave[gpos] = ~wave[gpos];
            end
            run_wave(pe, pt, "random");
            gap = int'($urandom_range(0, 3));
            if (gap > 0) idle(gap);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

UART receive path: recovers bytes from the asynchronous serial line using an oversampling clock enable-free scheme (fixed prescale of system clock per bit). It detects start bits, majority-votes each bit, deserializes LSB-first, checks optional parity and stop bit, and presents the parallel word with a one-cycle valid strobe. It is the receive counterpart of the TX serializer chain and feeds the system-side RX consumer.

## Interface
Parameters:
- DATA_WIDTH, 8, payload bits per frame (5..9)
- PRESCALE, 8, clk cycles per bit; legal 8, 16, 32

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- RX_IN  in  1  serial line, idle high; already synchronized upstream
- PAR_EN  in  1  1 = frame carries parity bit
- PAR_TYP  in  1  0 = even, 1 = odd
- P_DATA  out  DATA_WIDTH  last good received word
- data_valid  out  1  one-cycle strobe, P_DATA updated same cycle
- par_err  out  1  one-cycle strobe, parity mismatch
- stp_err  out  1  one-cycle strobe, stop bit sampled 0
- busy  out  1  high while a frame is in progress

## Operation
- FSM: IDLE, START, DATA, PARITY, STOP.
- IDLE: RX_IN==0 in a cycle -> START; that cycle is tick 0 of the start bit; PAR_EN/PAR_TYP latched; mid-frame changes ignored.
- edge_cnt counts 0..PRESCALE-1 per bit, wraps to 0 at each bit boundary; bit_cnt counts data bits 0..DATA_WIDTH-1.
- Samples taken at edge_cnt = PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1; bit value = majority of the three; decision applied at edge_cnt = PRESCALE-1.
- START: majority 1 -> glitch, back to IDLE, no strobe. Majority 0 -> DATA.
- DATA: shift LSB-first; after bit DATA_WIDTH-1 -> PARITY if PAR_EN else STOP.
- PARITY: expected = XOR of data (even) or XNOR (odd); mismatch recorded.
- STOP: majority 0 records stop error. At end of stop bit: no error -> P_DATA <= shift register, data_valid=1; parity error -> par_err=1; stop error -> stp_err=1 (both may pulse together); P_DATA unchanged on any error. Return to IDLE.
- busy = state != IDLE.

## Timing
- Reset values: P_DATA=0, data_valid=0, par_err=0, stp_err=0, busy=0, FSM IDLE, counters 0.
- Strobes registered, exactly one cycle wide, asserted on the clock edge ending the stop bit: (2+DATA_WIDTH+PAR_EN)*PRESCALE cycles after the start-detect edge.
- Strobe cycle FSM is IDLE; RX_IN==0 in that same cycle starts the next frame (back-to-back frames, zero gap).
- Glitch rejection: busy drops PRESCALE cycles after detect.
- rst mid-frame: next edge returns to IDLE, partial frame discarded, no strobe, P_DATA cleared to 0.
- Line low continuously (break): start accepted, data 0, stop error reported; FSM then re-arms on the still-low line.

## Structure
- Shared package uart_pkg: FSM state enum, PAR_EVEN/PAR_ODD constants, prescale legality check function (also used by TX).
- One sub-module: uart_rx_data_sampler (three-tap capture plus majority vote, driven by edge_cnt); FSM, counters, deserializer and checks stay in uart_rx_core.

## Test plan
(PRESCALE=8, DATA_WIDTH=8)
- 0xA5, PAR_EN=0, clean frame -> data_valid one cycle at 80 cycles after detect, P_DATA=0xA5, no errors.
- 0x3C, PAR_EN=1, even, parity bit 0 -> data_valid at 88, P_DATA=0x3C. Repeat with parity bit 1 -> par_err pulse, data_valid stays 0, P_DATA stays 0x3C.
- 0x5A with stop bit 0 -> stp_err pulse, no data_valid; next frame 0x81 received correctly.
- RX_IN low for 3 cycles then high -> no strobes, busy low 8 cycles after detect.
- 0xF0 with 1-cycle inverted pulse at edge_cnt=4 of bit 2 -> majority recovers, P_DATA=0xF0.
- Two back-to-back frames 0x11, 0x22 with zero idle gap, then rst asserted mid third frame at bit 4 -> valids for 0x11 and 0x22; no strobe for third; all outputs 0; following frame 0x33 received.
